md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Multiply/divide sequencer for the MIPS pipeline's HI/LO resource.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds HI/LO.
- Models multi-cycle occupancy with a down-counter and drives the busy status.
- Generates the MD-class stall request that the pipeline hazard logic ORs into its global stall.

Parameters:
- MULT_CYCLES, 5, cycles Busy is held for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles Busy is held for div/divu (legal range 1..15).

Ports:
- Clk  input  1  clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  E-stage MD instruction valid this cycle.
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  input  32  forwarded RS operand, E stage.
- B  input  32  forwarded RT operand, E stage.
- Cancel  input  1  exception/interrupt flush: aborts the in-flight op and blocks Start.
- MD_D  input  1  D-stage instruction is MD class (mult/div/mfhi/mflo/mthi/mtlo).
- Busy  output  1  an operation is in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.
- Stall_MD  output  1  stall request to the hazard unit.

Behaviour:
- Reset (synchronous) forces:
  - state IDLE, count 0;
  - Busy=0, HI=0, LO=0;
  - pending result registers = 0.
- Reset overrides everything, including an op in flight; no HI/LO write occurs.
- States:
  - IDLE → RUN on accepted Start with MDOp 1..4;
  - RUN → IDLE when count reaches 1 (commit) or on Cancel (abort).
- Start is accepted only when state is IDLE, Cancel=0 and MDOp is not 0 or 7. Otherwise it is ignored with no side effects.
- Start while RUN is ignored; the hazard logic guarantees it cannot occur.
- Accepted mult/div at edge k:
  - result computed from A/B sampled at edge k into pending regs;
  - count loaded with MULT_CYCLES or DIV_CYCLES;
  - Busy=1 after edge k.
- Each RUN edge decrements count. At the edge where count==1, HI/LO take the pending values, state returns to IDLE and Busy goes to 0.
  - Net timing: Busy is high for exactly N cycles, and new HI/LO are visible in the cycle Busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 → 64, HI=[63:32], LO=[31:0].
  - multu: same as mult, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Divide by zero: full DIV_CYCLES busy period, then HI/LO unchanged.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: accepted in IDLE, HI (or LO) written with A at the same edge. Busy stays 0 and there is no RUN.
- Cancel:
  - in RUN: return to IDLE next edge, Busy=0, HI/LO keep pre-op values, pending result discarded;
  - in IDLE: blocks Start that cycle.
- Stall_MD (combinational) = MD_D && (Busy || (Start && MDOp in 1..4 && !Cancel)).
  - This stalls the D-stage MD instruction from the issue cycle until the cycle Busy falls.
  - The stall is released in the same cycle HI/LO update, so a following mfhi/mflo reads committed values.
- HI/LO change only at: reset, mthi/mtlo edge, commit edge.

Test Plan:
- Reset, then Start mult with A=0xFFFFFFFD (-3), B=5 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Busy=0.
- Start divu A=7, B=2 → Busy high 10 cycles; LO=3, HI=1. Then div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Stall: MD_D=1 with mflo in D while multu issues (A=0xFFFFFFFF, B=2) → Stall_MD=1 for the issue cycle plus 5 busy cycles, 0 when LO=0xFFFFFFFE, HI=1 appear.
- Cancel: preload HI=0x11, LO=0x22 via mthi/mtlo (Busy stays 0), start div, assert Cancel on busy cycle 4 → Busy=0 next cycle; HI=0x11, LO=0x22 unchanged.
- Edge cases: div by zero with HI=0xAA, LO=0xBB → 10 busy cycles, HI/LO unchanged. Div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Boundaries:
  - Reset asserted mid-mult → next cycle Busy=0, HI=LO=0.
  - Start during Busy → ignored; the result equals the first op only.
  - Start with Cancel=1 → not accepted, Busy stays 0.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO multiply/divide sequencer with busy countdown and MD-class stall request.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cancel,
   input  logic        MD_D,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Stall_MD
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic        pwe_q, pwe_d;
   logic        md_op, is_mult, is_div, sgn, accept;
   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr;
   assign md_op   = MDOp >= 3'd1 && MDOp <= 3'd4;
   assign is_mult = MDOp == 3'd1 || MDOp == 3'd2;
   assign is_div  = MDOp == 3'd3 || MDOp == 3'd4;
   assign sgn     = MDOp == 3'd3;
   assign accept  = Start && state_q == IDLE && !Cancel && MDOp != 3'd0 && MDOp != 3'd7;
   // low 64 bits of the sign-extended product equal the signed product
   assign prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u  = {32'b0, A} * {32'b0, B};
   // signed divide via magnitudes avoids the 0x80000000 / -1 overflow trap
   assign abs_a   = (sgn && A[31]) ? -A : A;
   assign abs_b   = (sgn && B[31]) ? -B : B;
   assign div_b   = (B == 32'd0) ? 32'd1 : abs_b;
   assign uq      = abs_a / div_b;
   assign ur      = abs_a % div_b;
   assign sq      = (sgn && (A[31] ^ B[31])) ? -uq : uq;
   assign sr      = (sgn && A[31]) ? -ur : ur;
   assign Busy     = state_q == RUN;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign Stall_MD = MD_D && (Busy || (Start && md_op && !Cancel));
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      pwe_d   = pwe_q;
      if (state_q == RUN) begin
         if (Cancel) begin
            state_d = IDLE;
            count_d = 4'd0;
         end else begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
               state_d = IDLE;
               hi_d    = pwe_q ? phi_q : hi_q;
               lo_d    = pwe_q ? plo_q : lo_q;
            end
         end
      end else if (accept) begin
         if (md_op) begin
            state_d = RUN;
            count_d = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            phi_d   = is_mult ? (MDOp == 3'd1 ? prod_s[63:32] : prod_u[63:32]) : sr;
            plo_d   = is_mult ? (MDOp == 3'd1 ? prod_s[31:0] : prod_u[31:0]) : sq;
            pwe_d   = !(is_div && B == 32'd0);
         end else begin
            hi_d = MDOp == 3'd5 ? A : hi_q;
            lo_d = MDOp == 3'd6 ? A : lo_q;
         end
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         pwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         pwe_q   <= pwe_d;
      end
   end
endmodule
